// File: rtl/task_pkg.sv
// Shared encodings and task-word layout for the per-level TaskFIFO producer.
// Word layout, MSB first: {type, treeId, data}.
package task_pkg;

   localparam logic TASK_PUSH = 1'b1;
   localparam logic TASK_POP  = 1'b0;

   localparam int DATA_LSB = 0;

   function automatic int task_w(input int ptw, input int tree_bits);
      return ptw + tree_bits + 1;
   endfunction

   function automatic int type_pos(input int ptw, input int tree_bits);
      return ptw + tree_bits;
   endfunction

   function automatic int tree_lsb(input int ptw);
      return ptw;
   endfunction

endpackage

// File: rtl/task_lane_fifo.sv
// Single-clock lane FIFO with a registered read-data output; one-cycle write-to-visible latency.
// A pop while empty is ignored. The caller must not write while full, because the FIFO has no bypass.
module task_lane_fifo #(
   parameter int W     = 19,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_wr_en,
   input  logic [W-1:0]  i_wr_dat,
   input  logic          i_rd_en,
   output logic [W-1:0]  o_rd_dat,
   output logic          o_empty,
   output logic          o_full,
   output logic [AW:0]   o_count
);

   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic [W-1:0]  dout_q, dout_d;
   logic          rd_eff;

   always_comb begin
      rd_eff = i_rd_en && (cnt_q != '0);
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      dout_d = dout_q;
      if (i_wr_en) begin
         wptr_d = wptr_q + PTR_ONE;
      end
      if (rd_eff) begin
         rptr_d = rptr_q + PTR_ONE;
         dout_d = mem_q[rptr_q];
      end
      case ({i_wr_en, rd_eff})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
         dout_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
      end
   end

   // Storage is not reset; the pointers alone define which entries are live.
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         mem_q[wptr_q] <= i_wr_dat;
      end
   end

   assign o_rd_dat = dout_q;
   assign o_empty  = (cnt_q == '0);
   assign o_full   = (cnt_q == DEPTH[AW:0]);
   assign o_count  = cnt_q;

endmodule

// File: rtl/task_enqueue.sv
// Steers push/pop requests to lane (treeId mod LEVEL), keeps per-tree pending counts and flags dropped requests.
// Entries become visible one cycle after accept. Ready is low only when the target lane is full or reset is asserted.
module task_enqueue
   import task_pkg::*;
#(
   parameter int PTW           = 16,
   parameter int LEVEL         = 4,
   parameter int LEVEL_BITS    = $clog2(LEVEL),
   parameter int TREE_NUM      = 4,
   parameter int TREE_NUM_BITS = $clog2(TREE_NUM),
   parameter int FIFO_DEPTH    = 16,
   parameter int CNT_W         = 16
) (
   input  logic                          i_clk,
   input  logic                          i_arst_n,
   input  logic                          i_req_valid,
   output logic                          o_req_ready,
   input  logic                          i_req_push,
   input  logic [TREE_NUM_BITS-1:0]      i_req_treeId,
   input  logic [PTW-1:0]                i_req_data,
   output logic                          o_drop,
   output logic [TREE_NUM_BITS-1:0]      o_drop_treeId,
   input  logic [LEVEL-1:0]              i_pop_TaskFIFO,
   output logic [PTW+TREE_NUM_BITS:0]    o_TaskFIFO_data [0:LEVEL-1],
   output logic [LEVEL-1:0]              o_TaskFIFO_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_lane_count [0:LEVEL-1]
);

   localparam int TW = task_w(PTW, TREE_NUM_BITS);
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [LEVEL_BITS-1:0]    lane;
   logic [LEVEL-1:0]         lane_full;
   logic [LEVEL-1:0]         lane_wr;
   logic [TW-1:0]            wr_word;
   logic                     is_push;
   logic                     accept;
   logic                     pend_ok;
   logic [CNT_W-1:0]         pend;
   logic [CNT_W-1:0]         pend_q [TREE_NUM];
   logic [CNT_W-1:0]         pend_d [TREE_NUM];
   logic                     drop_q, drop_d;
   logic [TREE_NUM_BITS-1:0] drop_tree_q, drop_tree_d;

   always_comb begin
      lane        = i_req_treeId[LEVEL_BITS-1:0];
      is_push     = (i_req_push == TASK_PUSH);
      o_req_ready = i_arst_n && !lane_full[lane];
      accept      = i_req_valid && o_req_ready;
      pend        = pend_q[i_req_treeId];
      pend_ok     = is_push ? (pend != '1) : (pend != '0);
      wr_word     = {is_push ? TASK_PUSH : TASK_POP, i_req_treeId,
                     is_push ? i_req_data : {PTW{1'b0}}};
      pend_d      = pend_q;
      lane_wr     = '0;
      drop_d      = 1'b0;
      drop_tree_d = drop_tree_q;
      if (accept) begin
         if (pend_ok) begin
            lane_wr[lane]        = 1'b1;
            pend_d[i_req_treeId] = is_push ? pend + CNT_ONE : pend - CNT_ONE;
         end else begin
            drop_d      = 1'b1;
            drop_tree_d = i_req_treeId;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_arst_n) begin
         pend_q      <= '{default: '0};
         drop_q      <= 1'b0;
         drop_tree_q <= '0;
      end else begin
         pend_q      <= pend_d;
         drop_q      <= drop_d;
         drop_tree_q <= drop_tree_d;
      end
   end

   assign o_drop        = drop_q;
   assign o_drop_treeId = drop_tree_q;

   for (genvar g = 0; g < LEVEL; g++) begin : g_lane
      task_lane_fifo #(
         .W     (TW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .i_clk    (i_clk),
         .i_rst_n  (i_arst_n),
         .i_wr_en  (lane_wr[g]),
         .i_wr_dat (wr_word),
         .i_rd_en  (i_pop_TaskFIFO[g]),
         .o_rd_dat (o_TaskFIFO_data[g]),
         .o_empty  (o_TaskFIFO_empty[g]),
         .o_full   (lane_full[g]),
         .o_count  (o_lane_count[g])
      );
   end

endmodule

// File: tb/tb_task_enqueue.sv
// Scoreboard bench for task_enqueue: small lanes and a 2-bit pending counter expose full and saturation edges.
module tb_task_enqueue;

   localparam int PTW        = 16;
   localparam int LEVEL      = 4;
   localparam int TREE_NUM   = 4;
   localparam int TNB        = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 2;
   localparam int TW         = PTW + TNB + 1;
   localparam int CW         = $clog2(FIFO_DEPTH) + 1;
   localparam int PEND_MAX   = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             arst_n;
   logic             req_valid;
   logic             req_ready;
   logic             req_push;
   logic [TNB-1:0]   req_tree;
   logic [PTW-1:0]   req_data;
   logic             drop;
   logic [TNB-1:0]   drop_tree;
   logic [LEVEL-1:0] pop;
   logic [TW-1:0]    fifo_data [0:LEVEL-1];
   logic [LEVEL-1:0] fifo_empty;
   logic [CW-1:0]    lane_count [0:LEVEL-1];

   always #5 clk = ~clk;

   task_enqueue #(
      .PTW        (PTW),
      .LEVEL      (LEVEL),
      .TREE_NUM   (TREE_NUM),
      .FIFO_DEPTH (FIFO_DEPTH),
      .CNT_W      (CNT_W)
   ) dut (
      .i_clk            (clk),
      .i_arst_n         (arst_n),
      .i_req_valid      (req_valid),
      .o_req_ready      (req_ready),
      .i_req_push       (req_push),
      .i_req_treeId     (req_tree),
      .i_req_data       (req_data),
      .o_drop           (drop),
      .o_drop_treeId    (drop_tree),
      .i_pop_TaskFIFO   (pop),
      .o_TaskFIFO_data  (fifo_data),
      .o_TaskFIFO_empty (fifo_empty),
      .o_lane_count     (lane_count)
   );

   int vec_cnt = 0;
   int err_cnt = 0;

   int          m_pend [TREE_NUM];
   logic [TW-1:0] m_lane [LEVEL][$];
   logic [TW-1:0] m_data [LEVEL];
   bit          m_drop;
   int          m_drop_tree;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int l = 0; l < LEVEL; l++) begin
         m_lane[l].delete();
         m_data[l] = '0;
      end
      for (int t = 0; t < TREE_NUM; t++) m_pend[t] = 0;
      m_drop = 1'b0;
   endtask

   task automatic check_outputs();
      for (int l = 0; l < LEVEL; l++) begin
         check_eq($sformatf("empty%0d", l), 32'(fifo_empty[l]), 32'(m_lane[l].size() == 0));
         check_eq($sformatf("count%0d", l), 32'(lane_count[l]), 32'(m_lane[l].size()));
         check_eq($sformatf("data%0d", l), 32'(fifo_data[l]), 32'(m_data[l]));
      end
      check_eq("drop", 32'(drop), 32'(m_drop));
      if (m_drop) check_eq("drop_tree", 32'(drop_tree), 32'(m_drop_tree));
   endtask

   // Called at a falling edge; drives one cycle and checks results at the next falling edge.
   task automatic step(input bit v, input bit psh, input int tree, input logic [PTW-1:0] dat,
                       input logic [LEVEL-1:0] pmask);
      int  ln;
      bit  exp_rdy;
      bit  ok;
      req_valid = v;
      req_push  = psh;
      req_tree  = TNB'(tree);
      req_data  = dat;
      pop       = pmask;
      ln        = tree % LEVEL;
      #1;
      exp_rdy = (m_lane[ln].size() < FIFO_DEPTH);
      check_eq($sformatf("ready_t%0d", tree), 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      m_drop = 1'b0;
      for (int l = 0; l < LEVEL; l++)
         if (pmask[l] && m_lane[l].size() > 0) m_data[l] = m_lane[l].pop_front();
      if (v && exp_rdy) begin
         ok = psh ? (m_pend[tree] < PEND_MAX) : (m_pend[tree] > 0);
         if (!ok) begin
            m_drop      = 1'b1;
            m_drop_tree = tree;
         end else if (psh) begin
            m_lane[ln].push_back({1'b1, TNB'(tree), dat});
            m_pend[tree]++;
         end else begin
            m_lane[ln].push_back({1'b0, TNB'(tree), {PTW{1'b0}}});
            m_pend[tree]--;
         end
      end
      @(negedge clk);
      req_valid = 1'b0;
      pop       = '0;
      check_outputs();
   endtask

   task automatic apply_reset();
      arst_n = 1'b0;
      #1;
      check_eq("ready_in_reset", 32'(req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      model_clear();
      check_outputs();
      check_eq("drop_tree_rst", 32'(drop_tree), 32'd0);
   endtask

   initial begin
      arst_n    = 1'b0;
      req_valid = 1'b0;
      req_push  = 1'b0;
      req_tree  = '0;
      req_data  = '0;
      pop       = '0;
      model_clear();
      @(negedge clk);
      apply_reset();

      // Basic push then pop on lane 2.
      step(1, 1, 2, 16'h00AB, 4'b0000);
      step(0, 0, 0, 16'h0000, 4'b0100);
      check_eq("lane2_word", 32'(fifo_data[2]), 32'h600AB);

      // Pop request to an empty tree drops for one cycle.
      step(1, 0, 1, 16'h0000, 4'b0000);
      step(0, 0, 1, 16'h0000, 4'b0000);

      // Fill lane 0 to FIFO_DEPTH.
      step(1, 1, 0, 16'h0001, 4'b0000);
      step(1, 1, 0, 16'h0002, 4'b0000);
      step(1, 1, 0, 16'h0003, 4'b0000);
      step(1, 0, 0, 16'hFFFF, 4'b0000);
      step(0, 0, 0, 16'h0000, 4'b0000);
      step(0, 0, 3, 16'h0000, 4'b0000);
      // Push while full and popping: push not readied, only the pop happens.
      step(1, 1, 0, 16'h0055, 4'b0001);
      step(0, 0, 0, 16'h0000, 4'b0001);
      step(0, 0, 0, 16'h0000, 4'b0001);
      step(0, 0, 0, 16'h0000, 4'b0001);
      step(0, 0, 0, 16'h0000, 4'b0001);

      // Push then pop-request on tree 3, then a further pop-request drops.
      step(1, 1, 3, 16'h1111, 4'b0000);
      step(1, 0, 3, 16'h0000, 4'b0000);
      step(0, 0, 3, 16'h0000, 4'b1000);
      check_eq("lane3_push", 32'(fifo_data[3]), 32'h71111);
      step(0, 0, 3, 16'h0000, 4'b1000);
      check_eq("lane3_pop", 32'(fifo_data[3]), 32'h30000);
      step(1, 0, 3, 16'h0000, 4'b0000);

      // Pending counter saturation on tree 3.
      for (int i = 0; i < PEND_MAX + 1; i++) step(1, 1, 3, 16'(16'h0A00 + i), 4'b0000);
      for (int i = 0; i < PEND_MAX; i++) step(0, 0, 3, 16'h0000, 4'b1000);

      // Write and pop on an empty lane 0 in the same cycle.
      step(1, 1, 0, 16'h0077, 4'b0001);
      step(0, 0, 0, 16'h0000, 4'b0001);

      // Reset with entries queued on lane 1; pop right after release is ignored.
      step(1, 1, 1, 16'h0101, 4'b0000);
      step(1, 1, 1, 16'h0102, 4'b0000);
      step(1, 1, 1, 16'h0103, 4'b0000);
      @(negedge clk);
      apply_reset();
      step(0, 0, 1, 16'h0000, 4'b0010);
      step(1, 0, 1, 16'h0000, 4'b0000);

      // Random traffic against the scoreboard.
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              int'($urandom_range(0, TREE_NUM - 1)), 16'($urandom()),
              LEVEL'($urandom_range(0, (1 << LEVEL) - 1) & $urandom_range(0, (1 << LEVEL) - 1)));

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
